// File: rtl/axis_stream_processor_pipe.sv
// axis_stream_processor_pipe
//   Inline AXI-Stream beat processor. Each accepted beat is transformed
//   (pass, byte reverse, add constant, XOR mask) and pushed into an output
//   FIFO that decouples upstream from downstream backpressure. Mode and
//   constant are latched at packet start so a packet is processed uniformly.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   s_axis_*              upstream slave stream (tdata/tkeep/tvalid/tlast/tready)
//   m_axis_*              downstream master stream, driven from the FIFO head
//   mode                  0 pass, 1 byte reverse, 2 add, 3 XOR, others pass
//   constant_value        addend (mode 2) or XOR mask (mode 3)
//   fifo_level            current FIFO occupancy
//   beat_count            output beats transferred (wraps)
//   pkt_count             output packets transferred (wraps)
module axis_stream_processor_pipe #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned MODE_WIDTH  = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [TDATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]      s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic [MODE_WIDTH-1:0]         mode,
  input  logic [TDATA_WIDTH-1:0]        constant_value,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          beat_count,
  output logic [CNT_WIDTH-1:0]          pkt_count
);

  localparam int unsigned KeepW = TDATA_WIDTH / 8;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;

  typedef enum logic [0:0] {StIdle, StInPkt} state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic                    w_latch;
  logic [MODE_WIDTH-1:0]   r_mode;
  logic [TDATA_WIDTH-1:0]  r_const;
  logic                    r_areset_q;

  logic [TDATA_WIDTH-1:0]  r_data [FIFO_DEPTH];
  logic [KeepW-1:0]        r_keep [FIFO_DEPTH];
  logic                    r_last [FIFO_DEPTH];
  logic [AddrW-1:0]        r_wptr;
  logic [AddrW-1:0]        r_rptr;
  logic [LvlW-1:0]         r_level;
  logic [CNT_WIDTH-1:0]    r_beat_cnt;
  logic [CNT_WIDTH-1:0]    r_pkt_cnt;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_empty;
  logic [MODE_WIDTH-1:0]   w_eff_mode;
  logic [TDATA_WIDTH-1:0]  w_eff_const;
  logic [TDATA_WIDTH-1:0]  w_rev_data;
  logic [KeepW-1:0]        w_rev_keep;
  logic [TDATA_WIDTH-1:0]  w_data;
  logic [KeepW-1:0]        w_keep;

  // Handshakes. tready depends only on registered state (plus the reset input),
  // never on m_axis_tready.
  assign w_empty       = (r_level == '0);
  assign s_axis_tready = !areset && !r_areset_q && (r_level < LvlW'(FIFO_DEPTH));
  assign w_push        = s_axis_tvalid && s_axis_tready;
  assign w_pop         = m_axis_tvalid && m_axis_tready;

  // Packet start beats use the live controls; later beats use the latched ones.
  assign w_eff_mode  = (r_state == StIdle) ? mode : r_mode;
  assign w_eff_const = (r_state == StIdle) ? constant_value : r_const;

  always_comb begin
    w_rev_data = '0;
    w_rev_keep = '0;
    for (int i = 0; i < KeepW; i++) begin
      w_rev_data[8*i +: 8] = s_axis_tdata[8*(KeepW-1-i) +: 8];
      w_rev_keep[i]        = s_axis_tkeep[KeepW-1-i];
    end
  end

  always_comb begin
    w_data = s_axis_tdata;
    w_keep = s_axis_tkeep;
    if (w_eff_mode == MODE_WIDTH'(1)) begin
      w_data = w_rev_data;
      w_keep = w_rev_keep;
    end else if (w_eff_mode == MODE_WIDTH'(2)) begin
      w_data = s_axis_tdata + w_eff_const;
    end else if (w_eff_mode == MODE_WIDTH'(3)) begin
      w_data = s_axis_tdata ^ w_eff_const;
    end
  end

  // Mode latching FSM.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_push && !s_axis_tlast) begin
          w_state_next = StInPkt;
          w_latch      = 1'b1;
        end
      end
      StInPkt: begin
        if (w_push && s_axis_tlast) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_mode  <= '0;
      r_const <= '0;
    end else if (w_latch) begin
      r_mode  <= mode;
      r_const <= constant_value;
    end
  end

  always_ff @(posedge aclk) begin
    r_areset_q <= areset;
  end

  // FIFO storage needs no reset; the head is masked while empty.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_data[r_wptr] <= w_data;
      r_keep[r_wptr] <= w_keep;
      r_last[r_wptr] <= s_axis_tlast;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AddrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AddrW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LvlW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LvlW'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
      if (m_axis_tlast) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? '0 : r_data[r_rptr];
  assign m_axis_tkeep  = w_empty ? '0 : r_keep[r_rptr];
  assign m_axis_tlast  = w_empty ? 1'b0 : r_last[r_rptr];
  assign fifo_level    = r_level;
  assign beat_count    = r_beat_cnt;
  assign pkt_count     = r_pkt_cnt;

endmodule

// File: tb/tb_axis_stream_processor_pipe.sv
// Directed bench for axis_stream_processor_pipe: a table of single-beat
// transform vectors plus hand-written sequences for mode latching, FIFO
// stall/drain, sustained throughput and mid-packet reset. Stream outputs in
// the sequences are checked by a negedge monitor against an expected queue.
module tb_axis_stream_processor_pipe;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [1:0]  mode = '0;
  logic [31:0] cval = '0;
  logic [2:0]  level;
  logic [15:0] beat_count;
  logic [15:0] pkt_count;

  axis_stream_processor_pipe #(
    .TDATA_WIDTH(32),
    .MODE_WIDTH (2),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (16)
  ) dut (
    .aclk          (clk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .mode          (mode),
    .constant_value(cval),
    .fifo_level    (level),
    .beat_count    (beat_count),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int xfers = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] cval;
    logic [31:0] data;
    logic [3:0]  keep;
    logic [31:0] edata;
    logic [3:0]  ekeep;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.d = d;
    b.k = k;
    b.l = l;
    exp_q.push_back(b);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: tready still 0 after %0d cycles, required 1", n);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  // Stream monitor: a transfer happens at the next posedge when valid && ready.
  always @(negedge clk) begin
    #2;
    if (mon_en && m_tvalid && m_tready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: got %0h, expected no beat", m_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("stream_data", 64'(m_tdata), 64'(mon_e.d));
        chk("stream_keep", 64'(m_tkeep), 64'(mon_e.k));
        chk("stream_last", 64'(m_tlast), 64'(mon_e.l));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  initial begin
    int t0;
    int x0;
    vecs[0] = '{2'd1, 32'h0,        32'h11223344, 4'b0111, 32'h44332211, 4'b1110};
    vecs[1] = '{2'd2, 32'h00000002, 32'hFFFFFFFF, 4'b1111, 32'h00000001, 4'b1111};
    vecs[2] = '{2'd2, 32'h00000002, 32'h00000010, 4'b1111, 32'h00000012, 4'b1111};
    vecs[3] = '{2'd3, 32'hFFFF0000, 32'h12345678, 4'b1111, 32'hEDCB5678, 4'b1111};
    vecs[4] = '{2'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 4'b1010, 32'hDEADBEEF, 4'b1010};
    vecs[5] = '{2'd1, 32'h0,        32'hA1B2C3D4, 4'b0000, 32'hD4C3B2A1, 4'b0000};
    vecs[6] = '{2'd1, 32'h0,        32'h000000FF, 4'b0001, 32'hFF000000, 4'b1000};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_beats", 64'(beat_count), 64'd0);
    chk("rst_pkts", 64'(pkt_count), 64'd0);
    areset = 1'b0;
    #1;
    chk("tready_before_edge", 64'(s_tready), 64'd0);
    @(negedge clk);
    chk("tready_after_edge", 64'(s_tready), 64'd1);

    // Single-beat packets: live mode, one-cycle latency.
    m_tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mode     = vecs[i].mode;
      cval     = vecs[i].cval;
      s_tdata  = vecs[i].data;
      s_tkeep  = vecs[i].keep;
      s_tlast  = 1'b1;
      s_tvalid = 1'b1;
      @(negedge clk);
      s_tvalid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(m_tvalid), 64'd1);
      chk($sformatf("vec%0d_data", i), 64'(m_tdata), 64'(vecs[i].edata));
      chk($sformatf("vec%0d_keep", i), 64'(m_tkeep), 64'(vecs[i].ekeep));
      chk($sformatf("vec%0d_last", i), 64'(m_tlast), 64'd1);
    end
    @(negedge clk);
    chk("table_beats", 64'(beat_count), 64'd7);
    chk("table_pkts", 64'(pkt_count), 64'd7);
    chk("table_drained", 64'(m_tvalid), 64'd0);

    // Mode latched at packet start; change mid-packet applies next packet.
    mon_en = 1'b1;
    mode = 2'd3;
    cval = 32'hFFFF0000;
    push_exp(32'hFFFF0000, 4'hF, 1'b0);
    push_exp(32'hEEEE1111, 4'hF, 1'b0);
    push_exp(32'hDDDD2222, 4'hF, 1'b0);
    push_exp(32'hCCCC3333, 4'hF, 1'b1);
    push_exp(32'hAABBCCDD, 4'hF, 1'b1);
    send(32'h00000000, 4'hF, 1'b0);
    mode = 2'd0;
    cval = 32'h0;
    send(32'h11111111, 4'hF, 1'b0);
    send(32'h22222222, 4'hF, 1'b0);
    send(32'h33333333, 4'hF, 1'b1);
    send(32'hAABBCCDD, 4'hF, 1'b1);
    repeat (2) @(negedge clk);
    chk("latch_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("latch_beats", 64'(beat_count), 64'd12);
    chk("latch_pkts", 64'(pkt_count), 64'd9);

    // Stall with a full FIFO, then drain with no bubbles.
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) push_exp(32'h100 + 32'(i), 4'hF, (i == 5));
    for (int i = 0; i < 4; i++) send(32'h100 + 32'(i), 4'hF, 1'b0);
    s_tdata  = 32'h104;
    s_tkeep  = 4'hF;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_level", 64'(level), 64'd4);
      chk("stall_s_tready", 64'(s_tready), 64'd0);
      chk("stall_m_tvalid", 64'(m_tvalid), 64'd1);
      chk("stall_m_tdata", 64'(m_tdata), 64'h100);
    end
    x0 = xfers;
    m_tready = 1'b1;
    send(32'h104, 4'hF, 1'b0);
    send(32'h105, 4'hF, 1'b1);
    repeat (3) @(negedge clk);
    chk("drain_xfers", 64'(xfers - x0), 64'd6);
    chk("drain_empty", 64'(m_tvalid), 64'd0);
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_beats", 64'(beat_count), 64'd18);
    chk("drain_pkts", 64'(pkt_count), 64'd10);

    // Clear counters, then a 100-beat stream at full rate.
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) push_exp(32'(i) * 32'h01010101, 4'hF, (i % 10 == 9));
    t0 = cyc;
    x0 = xfers;
    for (int i = 0; i < 100; i++) send(32'(i) * 32'h01010101, 4'hF, (i % 10 == 9));
    chk("stream_cycles", 64'(cyc - t0), 64'd100);
    repeat (2) @(negedge clk);
    chk("stream_xfers", 64'(xfers - x0), 64'd100);
    chk("stream_beats", 64'(beat_count), 64'd100);
    chk("stream_pkts", 64'(pkt_count), 64'd10);

    // Reset mid-packet with 3 beats buffered.
    m_tready = 1'b0;
    mode = 2'd1;
    cval = 32'h0;
    for (int i = 0; i < 3; i++) send(32'h55 + 32'(i), 4'hF, 1'b0);
    chk("midpkt_level", 64'(level), 64'd3);
    areset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(m_tvalid), 64'd0);
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_beats", 64'(beat_count), 64'd0);
    chk("midrst_pkts", 64'(pkt_count), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    areset = 1'b0;
    @(negedge clk);
    mode = 2'd3;
    cval = 32'h0F0F0F0F;
    m_tready = 1'b1;
    push_exp(32'h1D3B5977, 4'hF, 1'b1);
    send(32'h12345678, 4'hF, 1'b1);
    repeat (2) @(negedge clk);
    chk("postrst_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("postrst_beats", 64'(beat_count), 64'd1);
    chk("postrst_pkts", 64'(pkt_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
